// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Parametrised pipeline stage register placed between two pipeline stages.
//   It holds a DATA_W payload and a CTRL_W control field under a valid/ready
//   handshake. It supports stall back-pressure, an optional 2-entry skid buffer,
//   flush/bubble insertion and a saturating stall counter.
//
// Parameters
//   DATA_W   payload width
//   CTRL_W   control field width (forced to zero on bubbles)
//   SKID     1 = 2-entry skid buffer with registered in_ready, 0 = single entry
//   STALL_W  width of stall_cnt
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream presents a beat
//   in_ready   stage can accept a beat (transfer on in_valid & in_ready)
//   in_data    upstream payload
//   in_ctrl    upstream control field
//   flush      squash every held entry at the next edge
//   out_valid  held beat valid toward downstream
//   out_ready  downstream accepts (transfer on out_valid & out_ready)
//   out_data   held payload
//   out_ctrl   held control field, zero whenever out_valid is low
//   stall_cnt  saturating count of cycles with out_valid & ~out_ready
module pipe_stage_reg #(
  parameter int DATA_W  = 16,
  parameter int CTRL_W  = 10,
  parameter int SKID    = 1,
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [STALL_W-1:0] stall_cnt
);

  // Main entry drives the outputs; the skid entry only exists when SKID=1.
  logic               mainValid_q, mainValid_d;
  logic [DATA_W-1:0]  mainData_q,  mainData_d;
  logic [CTRL_W-1:0]  mainCtrl_q,  mainCtrl_d;
  logic               skidValid_q, skidValid_d;
  logic [DATA_W-1:0]  skidData_q,  skidData_d;
  logic [CTRL_W-1:0]  skidCtrl_q,  skidCtrl_d;
  logic [STALL_W-1:0] stallCnt_q,  stallCnt_d;

  logic inFire;
  logic outFire;

  // With a skid buffer in_ready comes straight from a flop, so there is no
  // combinational path from out_ready back to in_ready.
  generate
    if (SKID != 0) begin : gReadySkid
      assign in_ready = ~skidValid_q;
    end else begin : gReadyDirect
      assign in_ready = ~mainValid_q | out_ready;
    end
  endgenerate

  assign inFire  = in_valid & in_ready;
  assign outFire = mainValid_q & out_ready;

  // Next-state for both entries. The skid always drains into main before new
  // input is taken, which keeps the ordering strictly FIFO. Whenever an entry
  // empties its control field is cleared so stale enables never leak out.
  always_comb begin
    mainValid_d = mainValid_q;
    mainData_d  = mainData_q;
    mainCtrl_d  = mainCtrl_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    skidCtrl_d  = skidCtrl_q;

    if (flush) begin
      // Data is left in place; only valids and control are squashed.
      mainValid_d = 1'b0;
      mainCtrl_d  = '0;
      skidValid_d = 1'b0;
      skidCtrl_d  = '0;
    end else if (!mainValid_q || outFire) begin
      if (skidValid_q) begin
        mainValid_d = 1'b1;
        mainData_d  = skidData_q;
        mainCtrl_d  = skidCtrl_q;
        skidValid_d = 1'b0;
        skidCtrl_d  = '0;
      end else if (inFire) begin
        mainValid_d = 1'b1;
        mainData_d  = in_data;
        mainCtrl_d  = in_ctrl;
      end else begin
        mainValid_d = 1'b0;
        mainCtrl_d  = '0;
      end
    end else if (inFire && (SKID != 0)) begin
      // Main is full and stalled: park the accepted beat in the skid entry.
      skidValid_d = 1'b1;
      skidData_d  = in_data;
      skidCtrl_d  = in_ctrl;
    end
  end

  // Stall counter saturates at all-ones; flush does not touch it.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (mainValid_q && !out_ready && (stallCnt_q != {STALL_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + STALL_W'(1);
    end
  end

  // State registers with synchronous reset that overrides flush and transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mainValid_q <= 1'b0;
      mainData_q  <= '0;
      mainCtrl_q  <= '0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      skidCtrl_q  <= '0;
      stallCnt_q  <= '0;
    end else begin
      mainValid_q <= mainValid_d;
      mainData_q  <= mainData_d;
      mainCtrl_q  <= mainCtrl_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
      skidCtrl_q  <= skidCtrl_d;
      stallCnt_q  <= stallCnt_d;
    end
  end

  // Control is gated by valid so an empty slot always reads as a bubble.
  assign out_valid = mainValid_q;
  assign out_data  = mainData_q;
  assign out_ctrl  = mainValid_q ? mainCtrl_q : '0;
  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg. Instance dutA is the skid-buffer build
//   (SKID=1), instance dutB the single-entry build (SKID=0); both use a 4-bit
//   stall counter so saturation is reachable quickly.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;

  logic        inValidA, inReadyA, flushA, outValidA, outReadyA;
  logic [15:0] inDataA, outDataA;
  logic [9:0]  inCtrlA, outCtrlA;
  logic [3:0]  stallCntA;

  logic        inValidB, inReadyB, flushB, outValidB, outReadyB;
  logic [15:0] inDataB, outDataB;
  logic [9:0]  inCtrlB, outCtrlB;
  logic [3:0]  stallCntB;

  int nChecks = 0;
  int nFail   = 0;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(10), .SKID(1), .STALL_W(4)) dutA (
    .clk(clk), .rst(rst),
    .in_valid(inValidA), .in_ready(inReadyA), .in_data(inDataA), .in_ctrl(inCtrlA),
    .flush(flushA),
    .out_valid(outValidA), .out_ready(outReadyA), .out_data(outDataA), .out_ctrl(outCtrlA),
    .stall_cnt(stallCntA)
  );

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(10), .SKID(0), .STALL_W(4)) dutB (
    .clk(clk), .rst(rst),
    .in_valid(inValidB), .in_ready(inReadyB), .in_data(inDataB), .in_ctrl(inCtrlB),
    .flush(flushB),
    .out_valid(outValidB), .out_ready(outReadyB), .out_data(outDataB), .out_ctrl(outCtrlB),
    .stall_cnt(stallCntB)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge so registered outputs are settled.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Drive all inputs of the skid instance in one go.
  task automatic applyStimulus(input logic vld, input logic [15:0] data,
                               input logic [9:0] ctrl, input logic ordy,
                               input logic fl);
    inValidA  = vld;
    inDataA   = data;
    inCtrlA   = ctrl;
    outReadyA = ordy;
    flushA    = fl;
    #1;
  endtask

  // One comparison: count it, and report a failure with observed/expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic        modelValid;
    logic [15:0] modelData;
    logic [15:0] nextSend;
    logic [15:0] nextRecv;
    logic        expReady;
    logic        inFireM;
    logic        outFireM;

    rst = 1'b1;
    inValidA = 1'b0; inDataA = '0; inCtrlA = '0; flushA = 1'b0; outReadyA = 1'b0;
    inValidB = 1'b0; inDataB = '0; inCtrlB = '0; flushB = 1'b0; outReadyB = 1'b0;

    // ---------------- initial reset ----------------
    stepClock();
    stepClock();
    checkOutput("rstA_out_valid", 32'(outValidA), 32'd0);
    checkOutput("rstA_out_ctrl",  32'(outCtrlA),  32'd0);
    checkOutput("rstA_out_data",  32'(outDataA),  32'd0);
    checkOutput("rstA_stall_cnt", 32'(stallCntA), 32'd0);
    checkOutput("rstB_out_valid", 32'(outValidB), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rstA_in_ready",  32'(inReadyA),  32'd1);
    checkOutput("rstB_in_ready",  32'(inReadyB),  32'd1);

    // ---------------- streaming through the skid build ----------------
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 16'(i), 10'h200 | 10'(i), 1'b1, 1'b0);
      checkOutput("stream_in_ready", 32'(inReadyA), 32'd1);
      stepClock();
      checkOutput("stream_out_valid", 32'(outValidA), 32'd1);
      checkOutput("stream_out_data",  32'(outDataA),  32'(i));
      checkOutput("stream_out_ctrl",  32'(outCtrlA),  32'(10'h200 | 10'(i)));
    end
    applyStimulus(1'b0, 16'h0, 10'h0, 1'b1, 1'b0);
    stepClock();
    checkOutput("stream_drain_valid", 32'(outValidA), 32'd0);
    checkOutput("stream_drain_ctrl",  32'(outCtrlA),  32'd0);
    checkOutput("stream_stall_cnt",   32'(stallCntA), 32'd0);

    // ---------------- skid fill and drain ----------------
    applyStimulus(1'b1, 16'h1111, 10'h011, 1'b0, 1'b0);
    stepClock();
    checkOutput("skid_A_valid",    32'(outValidA), 32'd1);
    checkOutput("skid_A_data",     32'(outDataA),  32'h1111);
    checkOutput("skid_A_in_ready", 32'(inReadyA),  32'd1);
    applyStimulus(1'b1, 16'h2222, 10'h022, 1'b0, 1'b0);
    stepClock();
    checkOutput("skid_B_in_ready", 32'(inReadyA),  32'd0);
    checkOutput("skid_B_head",     32'(outDataA),  32'h1111);
    checkOutput("skid_B_stall",    32'(stallCntA), 32'd1);
    applyStimulus(1'b0, 16'h0, 10'h0, 1'b1, 1'b0);
    stepClock();
    checkOutput("skid_move_valid",    32'(outValidA), 32'd1);
    checkOutput("skid_move_data",     32'(outDataA),  32'h2222);
    checkOutput("skid_move_ctrl",     32'(outCtrlA),  32'h022);
    checkOutput("skid_move_in_ready", 32'(inReadyA),  32'd1);
    stepClock();
    checkOutput("skid_empty_valid", 32'(outValidA), 32'd0);
    checkOutput("skid_empty_ctrl",  32'(outCtrlA),  32'd0);

    // ---------------- flush with both entries full ----------------
    applyStimulus(1'b1, 16'h3333, 10'h033, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 16'h4444, 10'h044, 1'b0, 1'b0);
    stepClock();
    checkOutput("flush_pre_in_ready", 32'(inReadyA), 32'd0);
    applyStimulus(1'b1, 16'h5555, 10'h055, 1'b0, 1'b1);
    stepClock();
    checkOutput("flush_out_valid", 32'(outValidA), 32'd0);
    checkOutput("flush_out_ctrl",  32'(outCtrlA),  32'd0);
    checkOutput("flush_in_ready",  32'(inReadyA),  32'd1);
    checkOutput("flush_data_hold", 32'(outDataA),  32'h3333);
    checkOutput("flush_stall",     32'(stallCntA), 32'd3);
    applyStimulus(1'b0, 16'h0, 10'h0, 1'b1, 1'b0);
    stepClock();
    checkOutput("flush_no_ghost_valid", 32'(outValidA), 32'd0);
    checkOutput("flush_no_ghost_data",  32'(outDataA),  32'h3333);

    // ---------------- stall counter saturation ----------------
    applyStimulus(1'b1, 16'h6666, 10'h066, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 16'h0, 10'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) stepClock();
    checkOutput("sat_out_valid", 32'(outValidA), 32'd1);
    checkOutput("sat_out_data",  32'(outDataA),  32'h6666);
    checkOutput("sat_stall_cnt", 32'(stallCntA), 32'd15);
    applyStimulus(1'b0, 16'h0, 10'h0, 1'b0, 1'b1);
    stepClock();
    checkOutput("sat_flush_valid", 32'(outValidA), 32'd0);
    checkOutput("sat_flush_stall", 32'(stallCntA), 32'd15);
    applyStimulus(1'b0, 16'h0, 10'h0, 1'b0, 1'b0);
    stepClock();
    checkOutput("sat_hold_stall", 32'(stallCntA), 32'd15);

    // ---------------- reset mid-traffic ----------------
    applyStimulus(1'b1, 16'h7777, 10'h077, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 16'h8888, 10'h088, 1'b0, 1'b0);
    stepClock();
    checkOutput("mid_pre_in_ready", 32'(inReadyA), 32'd0);
    rst = 1'b1;
    stepClock();
    stepClock();
    checkOutput("mid_rst_valid", 32'(outValidA), 32'd0);
    checkOutput("mid_rst_ctrl",  32'(outCtrlA),  32'd0);
    checkOutput("mid_rst_stall", 32'(stallCntA), 32'd0);
    checkOutput("mid_rst_data",  32'(outDataA),  32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 10'h0, 1'b0, 1'b0);
    stepClock();
    checkOutput("mid_rst_in_ready", 32'(inReadyA),  32'd1);
    checkOutput("mid_rst_no_ghost", 32'(outValidA), 32'd0);

    // ---------------- single-entry build, toggling out_ready ----------------
    modelValid = 1'b0;
    modelData  = '0;
    nextSend   = 16'h00A1;
    nextRecv   = 16'h00A1;
    for (int c = 0; c < 14; c++) begin
      inValidB  = 1'b1;
      inDataB   = nextSend;
      inCtrlB   = nextSend[9:0];
      outReadyB = (c % 2 == 0);
      #1;
      expReady = ~modelValid | outReadyB;
      checkOutput("tog_in_ready", 32'(inReadyB), 32'(expReady));
      inFireM  = expReady;
      outFireM = modelValid & outReadyB;
      if (outFireM) begin
        checkOutput("tog_deliver", 32'(outDataB), 32'(nextRecv));
        nextRecv = nextRecv + 16'd1;
      end
      stepClock();
      if (!modelValid || outFireM) begin
        modelValid = inFireM;
        if (inFireM) modelData = nextSend;
      end
      if (inFireM) nextSend = nextSend + 16'd1;
      checkOutput("tog_out_valid", 32'(outValidB), 32'(modelValid));
      if (modelValid) checkOutput("tog_out_data", 32'(outDataB), 32'(modelData));
    end
    inValidB  = 1'b0;
    outReadyB = 1'b1;
    #1;
    if (outValidB === 1'b1) begin
      checkOutput("tog_last_deliver", 32'(outDataB), 32'(nextRecv));
      nextRecv = nextRecv + 16'd1;
    end
    stepClock();
    checkOutput("tog_drain_valid", 32'(outValidB), 32'd0);
    checkOutput("tog_count",       32'(nextRecv),  32'(nextSend));

    // ---------------- single-entry flush with in and out fire ----------------
    inValidB = 1'b1; inDataB = 16'h0B01; inCtrlB = 10'h101; outReadyB = 1'b0;
    stepClock();
    checkOutput("b_flush_pre_valid", 32'(outValidB), 32'd1);
    inDataB = 16'h0B02; inCtrlB = 10'h102; outReadyB = 1'b1; flushB = 1'b1;
    #1;
    checkOutput("b_flush_in_ready", 32'(inReadyB), 32'd1);
    stepClock();
    flushB = 1'b0; inValidB = 1'b0; outReadyB = 1'b0;
    #1;
    checkOutput("b_flush_valid",        32'(outValidB), 32'd0);
    checkOutput("b_flush_ctrl",         32'(outCtrlB),  32'd0);
    checkOutput("b_flush_in_ready_out", 32'(inReadyB),  32'd1);
    stepClock();
    checkOutput("b_flush_no_ghost", 32'(outValidB), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
